master_port: RTL and testbench

MASTER_PORT -- requirements
Module: master_port

---
 rtl/master_port.sv | 163 ++++++++++++++++
 tb/tb_master_port.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/master_port.sv
// master_port: serial bus master. A device-side request is latched, the bus is
// requested, then address and (for writes) data are shifted out LSB first.
// Read data is collected bit by bit from the slave. The slave may split a read.
// Optional watchdog for RWAIT/WDONE: define MASTER_PORT_TIMEOUT_EN.
module master_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  dvalid,
  input  logic                  dmode,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [DATA_WIDTH-1:0] dwdata,
  output logic                  dready,
  output logic [DATA_WIDTH-1:0] drdata,
  output logic                  ddone,
  output logic                  derr,
  output logic                  mbreq,
  input  logic                  mbgrant,
  output logic                  mwdata,
  output logic                  mmode,
  output logic                  mvalid,
  input  logic                  srdata,
  input  logic                  svalid,
  input  logic                  sready,
  input  logic                  ssplit,
  output logic                  msplit
);

  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = $clog2(MAXW + 1);

  typedef enum logic [2:0] {
    IDLE, REQ, ADDR, GAP, WDATA, WDONE, RWAIT, DONE
  } state_t;

  state_t                state, next_state;
  logic [CW-1:0]         cnt, next_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rbuf, rbuf_next;
  logic                  mode_q;
  logic                  mwdata_next;
  logic                  msplit_next;
  logic                  timeout;

`ifdef MASTER_PORT_TIMEOUT_EN
  logic [7:0]            wd;
`endif

  assign dready = (state == IDLE);

  // Next-state, per-phase bit counter, read assembly and watchdog expiry
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    rbuf_next  = rbuf;
    timeout    = 1'b0;
    case (state)
      IDLE:  if (dvalid) next_state = REQ;
      REQ:   if (mbgrant && sready) next_state = ADDR;
      ADDR: begin
        if (cnt == CW'(ADDR_WIDTH - 1)) next_state = mode_q ? GAP : RWAIT;
        else                            next_cnt   = cnt + 1'b1;
      end
      GAP:   next_state = WDATA;
      WDATA: begin
        if (cnt == CW'(DATA_WIDTH - 1)) next_state = WDONE;
        else                            next_cnt   = cnt + 1'b1;
      end
      WDONE: if (sready) next_state = DONE;
      RWAIT: begin
        if (svalid) begin
          for (int i = 0; i < DATA_WIDTH; i++) begin
            if (cnt == CW'(i)) rbuf_next[i] = srdata;
          end
          if (cnt == CW'(DATA_WIDTH - 1)) next_state = DONE;
          else                            next_cnt   = cnt + 1'b1;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
`ifdef MASTER_PORT_TIMEOUT_EN
    if ((state == RWAIT || state == WDONE) && next_state == state &&
        !svalid && !ssplit && wd == 8'd254) begin
      next_state = DONE;
      timeout    = 1'b1;
    end
`endif
    if (next_state != state) next_cnt = '0;
  end

  // Serial bit for the cycle being entered, and the split flag update
  always_comb begin
    mwdata_next = 1'b0;
    if (next_state == ADDR) begin
      for (int i = 0; i < ADDR_WIDTH; i++) begin
        if (next_cnt == CW'(i)) mwdata_next = addr_q[i];
      end
    end else if (next_state == WDATA) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (next_cnt == CW'(i)) mwdata_next = wdata_q[i];
      end
    end
    msplit_next = (state == RWAIT) && (next_state == RWAIT) && !svalid &&
                  (msplit || ssplit);
  end

  // State, latched request and registered bus/device outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mode_q  <= 1'b0;
      rbuf    <= '0;
      mbreq   <= 1'b0;
      mvalid  <= 1'b0;
      mwdata  <= 1'b0;
      mmode   <= 1'b0;
      ddone   <= 1'b0;
      derr    <= 1'b0;
      msplit  <= 1'b0;
      drdata  <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (state == IDLE && dvalid) begin
        addr_q  <= daddr;
        wdata_q <= dwdata;
        mode_q  <= dmode;
        rbuf    <= '0;
      end else begin
        rbuf <= rbuf_next;
      end
      mbreq  <= next_state inside {REQ, ADDR, GAP, WDATA, WDONE, RWAIT};
      mvalid <= next_state inside {ADDR, WDATA};
      mwdata <= mwdata_next;
      mmode  <= (next_state inside {ADDR, GAP, WDATA, WDONE, RWAIT, DONE}) ? mode_q : 1'b0;
      ddone  <= (next_state == DONE);
      derr   <= timeout;
      msplit <= msplit_next;
      if (timeout)                                 drdata <= '0;
      else if (state == RWAIT && next_state == DONE) drdata <= rbuf_next;
    end
  end

`ifdef MASTER_PORT_TIMEOUT_EN
  // Watchdog: counts idle wait cycles, restarts on data or new state, holds during split
  always_ff @(posedge clk) begin
    if (!rstn)
      wd <= '0;
    else if (next_state != state || svalid || !(state inside {RWAIT, WDONE}))
      wd <= '0;
    else if (!ssplit)
      wd <= wd + 8'd1;
  end
`endif

endmodule

// File: tb/tb_master_port.sv
// tb_master_port: directed bench for master_port. Each transaction is turned
// into a per-cycle list of inputs and the outputs the bus protocol demands.
module tb_master_port;

  localparam int AW = 12;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rstn, dvalid, dmode, mbgrant, srdata, svalid, sready, ssplit;
  logic [AW-1:0] daddr;
  logic [DW-1:0] dwdata;
  logic          dready, ddone, derr, mbreq, mwdata, mmode, mvalid, msplit;
  logic [DW-1:0] drdata;

  master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn(rstn), .dvalid(dvalid), .dmode(dmode), .daddr(daddr),
    .dwdata(dwdata), .dready(dready), .drdata(drdata), .ddone(ddone),
    .derr(derr), .mbreq(mbreq), .mbgrant(mbgrant), .mwdata(mwdata),
    .mmode(mmode), .mvalid(mvalid), .srdata(srdata), .svalid(svalid),
    .sready(sready), .ssplit(ssplit), .msplit(msplit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          rstn, dvalid, dmode;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dwdata;
    logic          mbgrant, srdata, svalid, sready, ssplit;
  } in_t;

  typedef struct packed {
    logic          mbreq, mvalid, mwdata, mmode, ddone, derr, msplit, dready;
    logic [DW-1:0] drdata;
  } out_t;

  in_t     in_q[$];
  out_t    exp_q[$];
  out_t    cur_exp;
  bit      armed = 1'b0;
  int      cyc = 0;
  int      n_total = 0;
  int      n_bad = 0;
  logic [DW-1:0] last_rdata = '0;

  logic    cap[$];
  int      req_cycles, msplit_cnt, ddone_cnt, derr_seen, rd_val;
  bit      got_valid;

  // Expected output vectors
  function automatic in_t idleIn();
    in_t r;
    r = '0;
    r.rstn = 1'b1;
    r.sready = 1'b1;
    return r;
  endfunction

  function automatic out_t idleOut();
    out_t r;
    r = '0;
    r.dready = 1'b1;
    r.drdata = last_rdata;
    return r;
  endfunction

  function automatic out_t busyOut(input logic m);
    out_t r;
    r = '0;
    r.mbreq = 1'b1;
    r.mmode = m;
    r.drdata = last_rdata;
    return r;
  endfunction

  function automatic out_t doneOut(input logic m, input logic [DW-1:0] rd, input logic err);
    out_t r;
    r = '0;
    r.ddone = 1'b1;
    r.mmode = m;
    r.derr = err;
    r.drdata = rd;
    return r;
  endfunction

  function automatic out_t resetOut();
    out_t r;
    r = '0;
    r.dready = 1'b1;
    return r;
  endfunction

  task automatic push(input in_t i, input out_t o);
    in_q.push_back(i);
    exp_q.push_back(o);
  endtask

  // Request, bus wait and address phase (na address bits emitted)
  task automatic buildHead(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int g, input bit nr, input bit poke, input int na);
    in_t  i;
    out_t o;
    i = idleIn();
    i.dvalid = 1'b1; i.dmode = m; i.daddr = a; i.dwdata = d;
    push(i, busyOut(1'b0));
    for (int k = 0; k < g; k++) begin
      i = idleIn();
      if (nr) begin i.mbgrant = 1'b1; i.sready = 1'b0; end
      push(i, busyOut(1'b0));
    end
    for (int b = 0; b < na; b++) begin
      i = idleIn();
      i.sready = 1'b0;
      if (b == 0) begin i.mbgrant = 1'b1; i.sready = 1'b1; end
      if (poke && b == 3) begin
        i.dvalid = 1'b1; i.dmode = ~m; i.daddr = ~a; i.dwdata = ~d;
      end
      o = busyOut(m);
      o.mvalid = 1'b1;
      o.mwdata = a[b];
      push(i, o);
    end
  endtask

  task automatic buildWrite(input logic [AW-1:0] a, input logic [DW-1:0] d, input int g,
                            input bit nr, input bit poke, input int w);
    in_t  i;
    out_t o;
    buildHead(1'b1, a, d, g, nr, poke, AW);
    i = idleIn(); i.sready = 1'b0;
    push(i, busyOut(1'b1));
    for (int b = 0; b < DW; b++) begin
      o = busyOut(1'b1);
      o.mvalid = 1'b1;
      o.mwdata = d[b];
      push(i, o);
    end
    for (int k = 0; k < w; k++) push(i, busyOut(1'b1));
    push(idleIn(), doneOut(1'b1, last_rdata, 1'b0));
    push(idleIn(), idleOut());
  endtask

  task automatic buildRead(input logic [AW-1:0] a, input logic [DW-1:0] d, input int g,
                           input int sl, input int gp);
    in_t  i;
    out_t o;
    bit   ss, vs;
    ss = 1'b0;
    vs = 1'b0;
    buildHead(1'b0, a, d ^ 8'h5A, g, 1'b0, 1'b0, AW);
    i = idleIn(); i.sready = 1'b0;
    push(i, busyOut(1'b0));
    for (int s = 0; s < sl; s++) begin
      i = idleIn(); i.sready = 1'b0; i.ssplit = 1'b1;
      ss = 1'b1;
      o = busyOut(1'b0);
      o.msplit = ss && !vs;
      push(i, o);
    end
    for (int k = 0; k < DW; k++) begin
      for (int q = 0; q < gp; q++) begin
        i = idleIn(); i.sready = 1'b0; i.srdata = ~d[k];
        o = busyOut(1'b0);
        o.msplit = ss && !vs;
        push(i, o);
      end
      i = idleIn(); i.sready = 1'b0; i.svalid = 1'b1; i.srdata = d[k];
      vs = 1'b1;
      if (k == DW - 1) begin
        last_rdata = d;
        o = doneOut(1'b0, d, 1'b0);
      end else begin
        o = busyOut(1'b0);
      end
      push(i, o);
    end
    push(idleIn(), idleOut());
  endtask

  task automatic buildResetMid(input logic [AW-1:0] a);
    in_t i;
    buildHead(1'b1, a, 8'h3C, 0, 1'b0, 1'b0, 6);
    i = idleIn(); i.rstn = 1'b0;
    last_rdata = '0;
    push(i, resetOut());
    push(idleIn(), idleOut());
  endtask

  task automatic buildStall(input logic [AW-1:0] a);
    in_t i;
    buildHead(1'b0, a, 8'h00, 0, 1'b0, 1'b0, AW);
    i = idleIn(); i.sready = 1'b0;
    push(i, busyOut(1'b0));
`ifdef MASTER_PORT_TIMEOUT_EN
    for (int k = 0; k < 254; k++) push(i, busyOut(1'b0));
    last_rdata = '0;
    push(i, doneOut(1'b0, 8'h00, 1'b1));
    push(idleIn(), idleOut());
`else
    for (int k = 0; k < 1000; k++) push(i, busyOut(1'b0));
    i = idleIn(); i.rstn = 1'b0;
    last_rdata = '0;
    push(i, resetOut());
    push(idleIn(), idleOut());
`endif
  endtask

  task automatic drive(input in_t v);
    rstn = v.rstn; dvalid = v.dvalid; dmode = v.dmode; daddr = v.daddr;
    dwdata = v.dwdata; mbgrant = v.mbgrant; srdata = v.srdata;
    svalid = v.svalid; sready = v.sready; ssplit = v.ssplit;
  endtask

  task automatic observe();
    if (mvalid) begin cap.push_back(mwdata); got_valid = 1'b1; end
    if (mbreq && !mvalid && !got_valid) req_cycles++;
    if (msplit) msplit_cnt++;
    if (ddone) begin
      ddone_cnt++;
      rd_val = int'(drdata);
      if (derr) derr_seen = 1;
    end
  endtask

  // Plays the queued cycles; the compare process checks each resulting edge
  task automatic applyStimulus();
    cap.delete();
    req_cycles = 0; msplit_cnt = 0; ddone_cnt = 0; derr_seen = 0; rd_val = -1;
    got_valid = 1'b0;
    for (int t = 0; t < in_q.size(); t++) begin
      @(negedge clk);
      observe();
      drive(in_q[t]);
      cur_exp = exp_q[t];
      armed = 1'b1;
      cyc++;
    end
    @(negedge clk);
    observe();
    armed = 1'b0;
    in_q.delete();
    exp_q.delete();
  endtask

  task automatic checkOutput(input out_t e, input int c);
    out_t  a;
    string bad;
    a.mbreq = mbreq; a.mvalid = mvalid; a.mwdata = mwdata; a.mmode = mmode;
    a.ddone = ddone; a.derr = derr; a.msplit = msplit; a.dready = dready;
    a.drdata = drdata;
    bad = "";
    if (a.mbreq  !== e.mbreq)  bad = {bad, " mbreq"};
    if (a.mvalid !== e.mvalid) bad = {bad, " mvalid"};
    if (a.mwdata !== e.mwdata) bad = {bad, " mwdata"};
    if (a.mmode  !== e.mmode)  bad = {bad, " mmode"};
    if (a.ddone  !== e.ddone)  bad = {bad, " ddone"};
    if (a.derr   !== e.derr)   bad = {bad, " derr"};
    if (a.msplit !== e.msplit) bad = {bad, " msplit"};
    if (a.dready !== e.dready) bad = {bad, " dready"};
    if (a.drdata !== e.drdata) bad = {bad, " drdata"};
    n_total++;
    if (bad != "") begin
      n_bad++;
      $display("[TB] FAIL cycle_%0d%s: got %h want %h", c, bad, a, e);
    end
  endtask

  task automatic checkLit(input string name, input int act, input int req);
    n_total++;
    if (act != req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  function automatic int capWord(input int s, input int n);
    int v;
    v = 0;
    for (int i = 0; i < n; i++) begin
      if (s + i < cap.size() && cap[s + i] === 1'b1) v = v | (1 << i);
    end
    return v;
  endfunction

  // Compare DUT outputs with the expected vector just after each active edge
  always @(posedge clk) begin
    #1;
    if (armed) checkOutput(cur_exp, cyc);
  end

  // Hang guard
  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    in_t r;
    r = idleIn();
    r.rstn = 1'b0;
    drive(r);
    push(r, resetOut());
    push(r, resetOut());
    push(idleIn(), idleOut());
    push(idleIn(), idleOut());
    applyStimulus();
    checkLit("reset_dready", int'(dready), 1);
    checkLit("reset_mbreq", int'(mbreq), 0);

    $display("[TB] write 0x5A3 <- 0xC6");
    buildWrite(12'h5A3, 8'hC6, 0, 1'b0, 1'b0, 3);
    applyStimulus();
    checkLit("wr_bits", cap.size(), 20);
    checkLit("wr_addr", capWord(0, 12), 'h5A3);
    checkLit("wr_data", capWord(12, 8), 'hC6);
    checkLit("wr_done", ddone_cnt, 1);

    $display("[TB] read 0x010, 2 cycles per bit");
    buildRead(12'h010, 8'h3C, 0, 0, 1);
    applyStimulus();
    checkLit("rd_addr", capWord(0, 12), 'h010);
    checkLit("rd_data", rd_val, 'h3C);
    checkLit("rd_done", ddone_cnt, 1);
    checkLit("rd_err", derr_seen, 0);

    $display("[TB] split read");
    buildRead(12'h7FF, 8'hA5, 2, 4, 1);
    applyStimulus();
    checkLit("sp_msplit", msplit_cnt, 5);
    checkLit("sp_data", rd_val, 'hA5);

    $display("[TB] delayed grant, ignored dvalid, one-cycle WDONE");
    buildWrite(12'h0F0, 8'h81, 9, 1'b0, 1'b1, 1);
    applyStimulus();
    checkLit("gd_req", req_cycles, 10);
    checkLit("gd_done", ddone_cnt, 1);
    checkLit("gd_data", capWord(12, 8), 'h81);

    $display("[TB] back-to-back write then read");
    buildWrite(12'hABC, 8'h5A, 3, 1'b1, 1'b0, 2);
    buildRead(12'h001, 8'hFF, 0, 0, 0);
    applyStimulus();
    checkLit("bb_done", ddone_cnt, 2);
    checkLit("bb_data", rd_val, 'hFF);

    $display("[TB] reset during address bit 5");
    buildResetMid(12'hFFF);
    applyStimulus();
    checkLit("rm_done", ddone_cnt, 0);
    checkLit("rm_bits", cap.size(), 6);
    checkLit("rm_dready", int'(dready), 1);

    $display("[TB] read with no slave data");
    buildStall(12'h123);
    applyStimulus();
`ifdef MASTER_PORT_TIMEOUT_EN
    checkLit("to_done", ddone_cnt, 1);
    checkLit("to_err", derr_seen, 1);
    checkLit("to_data", rd_val, 0);
`else
    checkLit("st_done", ddone_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
